timer_counter: RTL and testbench

Counting core of the 8-bit timer IP. It sits directly downstream of the register block (TDR/TCR) and upstream of the status/interrupt logic that owns TSR. It holds TCNT, applies loads from TDR, and counts up or down on prescaled ticks. It raises one-cycle overflow/underflow set pulses only on genuine count transitions, never on loads.

---
 rtl/timer_pkg.sv | 26 ++
 rtl/timer_counter_if.sv | 25 ++
 rtl/timer_prescaler.sv | 42 ++++
 rtl/timer_counter.sv | 69 ++++++
 tb/tb_timer_counter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit timer IP: widths, clock-select codes,
// TCR bit positions and count-direction constants.
package timer_pkg;

    localparam int CNT_W_DEFAULT = 8;
    localparam int DIV_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        CKS_DIV2  = 2'b00,
        CKS_DIV4  = 2'b01,
        CKS_DIV8  = 2'b10,
        CKS_DIV16 = 2'b11
    } cks_e;

    localparam int TCR_LOAD = 7;
    localparam int TCR_EN   = 4;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Number of low prescaler bits that must all be ones for a tick at this cks.
    function automatic int cks_span(input logic [1:0] cks);
        return int'(cks) + 1;
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Control/status bundle between the register block, the counting core and
// the status block.
interface timer_counter_if #(
    parameter int CNT_W = 8
);
    logic             load;
    logic [CNT_W-1:0] tdr;
    logic             en;
    logic             dw;
    logic [1:0]       cks;
    logic [CNT_W-1:0] tcnt;
    logic             ovf_set;
    logic             udf_set;
    logic             tick_o;

    modport master (
        output load, tdr, en, dw, cks,
        input  tcnt, ovf_set, udf_set, tick_o
    );

    modport slave (
        input  load, tdr, en, dw, cks,
        output tcnt, ovf_set, udf_set, tick_o
    );
endinterface

// File: rtl/timer_prescaler.sv
// Free-running prescaler; tick is the AND of div[cks:0], one pulse every
// 2^(cks+1) cycles.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cks,
    output logic       tick_o
);

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] mask_s;
    logic             tick_s;

    // Divider register: only reset clears it, nothing else disturbs its phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= {DIV_W{1'b0}};
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Tick decode: cks selects how many low divider bits must be set.
    always_comb begin
        mask_s = {DIV_W{1'b0}};
        for (int i = 0; i < DIV_W; i++) begin
            if (i < cks_span(cks)) begin
                mask_s[i] = 1'b1;
            end else begin
                mask_s[i] = 1'b0;
            end
        end
        tick_s = ((div_r & mask_s) == mask_s);
    end

    assign tick_o = tick_s;

endmodule

// File: rtl/timer_counter.sv
// Counting core: holds TCNT, applies TDR loads and counts on prescaled ticks,
// raising registered one-cycle wrap pulses only on real count transitions.
module timer_counter
    import timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    timer_counter_if.slave  bus
);

    logic             tick_s;
    logic [CNT_W-1:0] tcnt_r;
    logic [CNT_W-1:0] tcnt_nxt_s;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic             udf_r;
    logic             udf_nxt_s;

    timer_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .cks    (bus.cks),
        .tick_o (tick_s)
    );

    // Next-state: load beats a coincident tick so reloads never look like wraps.
    always_comb begin
        tcnt_nxt_s = tcnt_r;
        ovf_nxt_s  = 1'b0;
        udf_nxt_s  = 1'b0;
        if (bus.load) begin
            tcnt_nxt_s = bus.tdr;
        end else if (bus.en && tick_s) begin
            if (bus.dw == DIR_DOWN) begin
                tcnt_nxt_s = tcnt_r - CNT_W'(1);
                udf_nxt_s  = (tcnt_r == {CNT_W{1'b0}});
            end else begin
                tcnt_nxt_s = tcnt_r + CNT_W'(1);
                ovf_nxt_s  = (tcnt_r == {CNT_W{1'b1}});
            end
        end else begin
            tcnt_nxt_s = tcnt_r;
        end
    end

    // Counter and flag registers share one edge so the pulse lines up with the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_r <= {CNT_W{1'b0}};
            ovf_r  <= 1'b0;
            udf_r  <= 1'b0;
        end else begin
            tcnt_r <= tcnt_nxt_s;
            ovf_r  <= ovf_nxt_s;
            udf_r  <= udf_nxt_s;
        end
    end

    assign bus.tcnt    = tcnt_r;
    assign bus.ovf_set = ovf_r;
    assign bus.udf_set = udf_r;
    assign bus.tick_o  = tick_s;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter.
module tb_timer_counter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    timer_counter_if #(.CNT_W(8)) bus ();

    timer_counter #(
        .CNT_W (8),
        .DIV_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (bus.tick_o !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        checks++;
        if (bus.tick_o !== 1'b1) begin
            errors++;
            $display("FAIL wait_tick: tick_o=%b after %0d cycles, expected 1", bus.tick_o, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.load = 1'b0; bus.tdr = 8'h00; bus.en = 1'b0;
        bus.dw = 1'b0; bus.cks = 2'b00;
        cyc(); cyc();
        chk8("reset_tcnt", bus.tcnt, 8'h00);
        chk1("reset_ovf", bus.ovf_set, 1'b0);
        chk1("reset_udf", bus.udf_set, 1'b0);
        chk1("reset_tick", bus.tick_o, 1'b0);
        rst = 1'b0; bus.en = 1'b1;
        repeat (5) cyc();
        bus.load = 1'b1; bus.tdr = 8'h5A; bus.en = 1'b0;
        cyc();
        bus.load = 1'b0; bus.en = 1'b1;
        chk8("midcount_load", bus.tcnt, 8'h5A);
        rst = 1'b1;
        cyc();
        chk8("midreset_tcnt", bus.tcnt, 8'h00);
        chk1("midreset_ovf", bus.ovf_set, 1'b0);
        chk1("midreset_udf", bus.udf_set, 1'b0);
        chk1("midreset_tick", bus.tick_o, 1'b0);
        rst = 1'b0; bus.en = 1'b0;
        cyc();
        chk1("post_reset_tick_c1", bus.tick_o, 1'b1);
        cyc();
        chk1("post_reset_tick_c2", bus.tick_o, 1'b0);
    endtask

    task automatic test_fake_underflow();
        bus.cks = 2'b00; bus.dw = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            bus.en = (pass == 1) ? 1'b1 : 1'b0;
            bus.load = 1'b1; bus.tdr = 8'h00;
            cyc();
            chk8("fake_load00", bus.tcnt, 8'h00);
            chk1("fake_udf_after00", bus.udf_set, 1'b0);
            bus.tdr = 8'hFF;
            cyc();
            bus.load = 1'b0; bus.en = 1'b0;
            chk8("fake_loadFF", bus.tcnt, 8'hFF);
            chk1("fake_udf_afterFF", bus.udf_set, 1'b0);
            cyc();
            chk1("fake_udf_later", bus.udf_set, 1'b0);
        end
    endtask

    task automatic test_underflow();
        bus.cks = 2'b00; bus.dw = 1'b1; bus.en = 1'b0;
        bus.load = 1'b1; bus.tdr = 8'h01;
        cyc();
        bus.load = 1'b0;
        wait_tick();
        bus.en = 1'b1;
        cyc();
        chk8("udf_tick1_tcnt", bus.tcnt, 8'h00);
        chk1("udf_tick1_flag", bus.udf_set, 1'b0);
        cyc();
        chk8("udf_hold_tcnt", bus.tcnt, 8'h00);
        chk1("udf_tick2_ready", bus.tick_o, 1'b1);
        cyc();
        chk8("udf_tick2_tcnt", bus.tcnt, 8'hFF);
        chk1("udf_tick2_flag", bus.udf_set, 1'b1);
        chk1("udf_tick2_ovf", bus.ovf_set, 1'b0);
        cyc();
        chk1("udf_pulse_width", bus.udf_set, 1'b0);
        chk8("udf_after_tcnt", bus.tcnt, 8'hFF);
        bus.en = 1'b0;
    endtask

    task automatic test_overflow();
        int gap;
        int ovf_seen;
        bus.cks = 2'b11; bus.dw = 1'b0; bus.en = 1'b0;
        bus.load = 1'b1; bus.tdr = 8'hFE;
        cyc();
        bus.load = 1'b0;
        wait_tick();
        bus.en = 1'b1;
        gap = 0; ovf_seen = 0;
        do begin
            cyc();
            gap++;
            if (bus.ovf_set === 1'b1) ovf_seen++;
        end while (bus.tick_o !== 1'b1 && gap < 40);
        chk8("ovf_tcnt_FF", bus.tcnt, 8'hFF);
        checks++;
        if (gap != 16) begin
            errors++;
            $display("FAIL ovf_tick_spacing: got %0d cycles, expected 16", gap);
        end
        checks++;
        if (ovf_seen != 0) begin
            errors++;
            $display("FAIL ovf_early: got %0d pulses, expected 0", ovf_seen);
        end
        cyc();
        chk8("ovf_wrap_tcnt", bus.tcnt, 8'h00);
        chk1("ovf_wrap_flag", bus.ovf_set, 1'b1);
        chk1("ovf_wrap_udf", bus.udf_set, 1'b0);
        cyc();
        chk1("ovf_pulse_width", bus.ovf_set, 1'b0);
        bus.en = 1'b0;
    endtask

    task automatic test_collision();
        bus.cks = 2'b00; bus.dw = 1'b0; bus.en = 1'b0;
        bus.load = 1'b1; bus.tdr = 8'hFF;
        cyc();
        bus.load = 1'b0;
        wait_tick();
        bus.en = 1'b1; bus.load = 1'b1; bus.tdr = 8'h00;
        cyc();
        bus.load = 1'b0; bus.en = 1'b0;
        chk8("collision_tcnt", bus.tcnt, 8'h00);
        chk1("collision_ovf", bus.ovf_set, 1'b0);
    endtask

    task automatic test_prescaler_sweep();
        int ticks;
        int exp_ticks;
        logic [7:0] start;
        for (int c = 0; c < 4; c++) begin
            exp_ticks = 64 >> (c + 1);
            bus.cks = 2'(c); bus.dw = 1'b0;
            for (int pass = 0; pass < 2; pass++) begin
                bus.en = 1'b0; bus.load = 1'b1; bus.tdr = 8'h10;
                cyc();
                bus.load = 1'b0;
                bus.en = (pass == 0) ? 1'b1 : 1'b0;
                start = 8'h10;
                ticks = 0;
                for (int i = 0; i < 64; i++) begin
                    if (bus.tick_o === 1'b1) ticks++;
                    cyc();
                end
                checks++;
                if (ticks != exp_ticks) begin
                    errors++;
                    $display("FAIL sweep_ticks cks=%0d en=%0d: got %0d, expected %0d",
                             c, 1 - pass, ticks, exp_ticks);
                end
                chk8("sweep_tcnt", bus.tcnt,
                     (pass == 0) ? 8'(start + 8'(exp_ticks)) : start);
            end
        end
        bus.en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fake_underflow();
        test_underflow();
        test_overflow();
        test_collision();
        test_prescaler_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
